// File: rtl/fifo_rptr_empty.sv
// Read-side pointer and empty/level logic for an asynchronous FIFO.
// Holds the binary and Gray read pointers and derives occupancy from the synchronized write pointer.
module fifo_rptr_empty #(
    parameter int ASIZE         = 4,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic             rinc,
    input  logic [ASIZE:0]   rq2_wptr,
    output logic [ASIZE:0]   rptr,
    output logic [ASIZE-1:0] raddr,
    output logic             rempty,
    output logic             ralmost_empty,
    output logic [ASIZE:0]   rlevel,
    output logic             runderflow
);

    localparam logic [ASIZE:0] THRESH = (ASIZE+1)'(AEMPTY_THRESH);

    logic [ASIZE:0] rbin;
    logic [ASIZE:0] rbinnext;
    logic [ASIZE:0] rgraynext;
    logic [ASIZE:0] wbin;
    logic [ASIZE:0] level_next;
    logic           accepted;

    // A read is only taken while the registered empty flag is clear.
    assign accepted   = rinc && !rempty;
    assign rbinnext   = rbin + {{ASIZE{1'b0}}, accepted};
    assign rgraynext  = (rbinnext >> 1) ^ rbinnext;
    assign raddr      = rbin[ASIZE-1:0];
    assign level_next = wbin - rbinnext;

    // Each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        wbin = '0;
        for (int i = 0; i <= ASIZE; i++) begin
            wbin[i] = ^(rq2_wptr >> i);
        end
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            rbin          <= '0;
            rptr          <= '0;
            rempty        <= 1'b1;
            ralmost_empty <= 1'b1;
            rlevel        <= '0;
            runderflow    <= 1'b0;
        end else begin
            rbin          <= rbinnext;
            rptr          <= rgraynext;
            rempty        <= (rgraynext == rq2_wptr);
            ralmost_empty <= (level_next <= THRESH);
            rlevel        <= level_next;
            if (rinc && rempty) begin
                runderflow <= 1'b1;
            end
        end
    end

endmodule
